// File: rtl/rv32i_types_pkg.sv
// Shared types for the vector element sequencer: SEW encoding, element
// offset width, VLEN, lane count, sequencer states and the latched op.
package rv32i_types_pkg;

  localparam int VLEN      = 128;
  localparam int NUM_LANES = 2;
  // Widest element-offset range is SEW=8: VLEN/8 elements per register.
  localparam int OFFSET_W  = $clog2(VLEN / 8);

  typedef logic [OFFSET_W-1:0] offset_t;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2
  } sew_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } vseq_state_t;

  // Fields captured on accept. vstart is not stored separately: it is
  // loaded into elem_idx, which then doubles as the restart point.
  typedef struct packed {
    logic [31:0] vl;
    sew_t        sew;
    logic [4:0]  vd;
    logic        is_masked;
  } vseq_op_t;

endpackage

// File: rtl/rv32v_element_sequencer_if.sv
// Decode-side request, execute-side write controls and status of the
// vector element sequencer. master = decode/execute side, slave = sequencer.
interface rv32v_element_sequencer_if;
  import rv32i_types_pkg::*;

  logic        decode_done;
  logic        ready;
  logic [31:0] vl;
  logic [31:0] vstart;
  sew_t        sew;
  logic [4:0]  vd;
  logic        is_masked;
  logic        mask0;
  logic        mask1;
  logic        stall;
  logic        flush;

  logic [1:0]  wen;
  logic [4:0]  vreg0;
  logic [4:0]  vreg1;
  offset_t     woffset0;
  offset_t     woffset1;
  logic [31:0] elem_idx;
  logic        busy;
  logic        done;

  modport master (
    output decode_done, vl, vstart, sew, vd, is_masked, mask0, mask1, stall, flush,
    input  ready, wen, vreg0, vreg1, woffset0, woffset1, elem_idx, busy, done
  );

  modport slave (
    input  decode_done, vl, vstart, sew, vd, is_masked, mask0, mask1, stall, flush,
    output ready, wen, vreg0, vreg1, woffset0, woffset1, elem_idx, busy, done
  );

endinterface

// File: rtl/rv32v_elem_offset.sv
// Maps one element index to its destination register and in-register
// offset: vreg = vd + idx/EPR (mod 32), woffset = idx mod EPR.
module rv32v_elem_offset
  import rv32i_types_pkg::*;
(
  input  logic [31:0] idx,
  input  sew_t        sew,
  input  logic [4:0]  vd,
  output logic [4:0]  vreg,
  output offset_t     woffset
);

  // EPR is a power of two, so divide/modulo reduce to shift/mask; the
  // 5-bit add wraps past v31 back to v0.
  always_comb begin
    case (sew)
      SEW_8: begin
        vreg    = vd + 5'(idx >> 4);
        woffset = idx[3:0];
      end
      SEW_16: begin
        vreg    = vd + 5'(idx >> 3);
        woffset = {1'b0, idx[2:0]};
      end
      default: begin
        vreg    = vd + 5'(idx >> 2);
        woffset = {2'b00, idx[1:0]};
      end
    endcase
  end

endmodule

// File: rtl/rv32v_element_sequencer.sv
// Steps a decoded vector op through its elements two at a time, producing
// per-lane write enables and (vreg, woffset) targets for execute.
module rv32v_element_sequencer
  import rv32i_types_pkg::*;
(
  input logic                       CLK,
  input logic                       nRST,
  rv32v_element_sequencer_if.slave  bus
);

  vseq_state_t state, state_n;
  vseq_op_t    op;
  logic [31:0] elem_idx;
  logic        accept, advance, run_en;

  logic [NUM_LANES-1:0][31:0] lane_idx;
  logic [NUM_LANES-1:0][4:0]  lane_vreg;
  offset_t [NUM_LANES-1:0]    lane_woff;
  logic [NUM_LANES-1:0]       lane_live;
  logic [NUM_LANES-1:0]       mask;
  logic [NUM_LANES-1:0]       wen;

  // 33-bit so elem_idx+2 near 2^32 cannot wrap and look "below vl".
  logic [32:0] idx_plus2;
  assign idx_plus2 = {1'b0, elem_idx} + 33'd2;
  assign mask      = {bus.mask1, bus.mask0};

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and handshake outputs; flush beats stall and decode_done.
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    advance   = 1'b0;
    run_en    = 1'b0;
    bus.ready = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        bus.ready = 1'b1;
        if (!bus.flush && bus.decode_done) begin
          accept  = 1'b1;
          state_n = (bus.vstart < bus.vl) ? RUN : DONE;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (bus.flush) begin
          state_n = IDLE;
        end else if (!bus.stall) begin
          run_en  = 1'b1;
          advance = 1'b1;
          if (idx_plus2 >= {1'b0, op.vl}) state_n = DONE;
        end
      end
      DONE: begin
        bus.busy = 1'b1;
        state_n  = IDLE;
        if (!bus.flush) bus.done = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Op capture on accept; element pointer steps by the lane count.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      op       <= '0;
      elem_idx <= '0;
    end else if (accept) begin
      op.vl        <= bus.vl;
      op.sew       <= bus.sew;
      op.vd        <= bus.vd;
      op.is_masked <= bus.is_masked;
      elem_idx     <= bus.vstart;
    end else if (advance) begin
      elem_idx <= idx_plus2[31:0];
    end
  end

  // Lane l handles element elem_idx+l; tail lanes past vl stay quiet.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign lane_idx[l]  = elem_idx + 32'(l);
    assign lane_live[l] = ({1'b0, elem_idx} + 33'(l)) < {1'b0, op.vl};
    assign wen[l]       = run_en && lane_live[l] && (!op.is_masked || mask[l]);

    rv32v_elem_offset u_off (
      .idx     (lane_idx[l]),
      .sew     (op.sew),
      .vd      (op.vd),
      .vreg    (lane_vreg[l]),
      .woffset (lane_woff[l])
    );
  end

  // Targets are only meaningful in RUN; elsewhere they read as zero.
  assign bus.wen      = wen;
  assign bus.vreg0    = (state == RUN) ? lane_vreg[0] : '0;
  assign bus.vreg1    = (state == RUN) ? lane_vreg[1] : '0;
  assign bus.woffset0 = (state == RUN) ? lane_woff[0] : '0;
  assign bus.woffset1 = (state == RUN) ? lane_woff[1] : '0;
  assign bus.elem_idx = elem_idx;

endmodule
